// File: rtl/simon_stream_ctrl.sv
// ---------------------------------------------------------------------------
// simon_stream_ctrl
//
// Sequencer between a host valid/ready stream and one SIMON_64128 core.
// Keys are latched and handed to the core through the newKey/loadKey
// handshake. Data blocks are queued in an input FIFO and issued one at a
// time through newData/loadData/doneData/readData. Results are collected
// in an output FIFO. Only one block is ever inside the core.
//
// Optional feature macro: SIMON_CBC_EN
//   defined   : CBC chaining around the core, iv port present
//   undefined : ECB, blocks pass straight through, no iv port
//
// Ports
//   clk, nR            clock, synchronous active-low reset (shared with core)
//   key_in/key_mode    key (word M-1 in MSBs) and mode (1=encrypt)
//   key_valid/ready    key handshake
//   in_block/valid/ready   input block stream
//   out_block/valid/ready  output block stream (FIFO head)
//   busy               FSM active or any FIFO non-empty
//   core_*             SIMON core handshake and data
//   iv                 CBC initial vector, sampled at key accept (CBC only)
// ---------------------------------------------------------------------------
module simon_stream_ctrl #(
  parameter int N         = 32,
  parameter int M         = 4,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic             clk,
  input  logic             nR,
  input  logic [M*N-1:0]   key_in,
  input  logic             key_mode,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [2*N-1:0]   in_block,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [2*N-1:0]   out_block,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             core_newKey,
  input  logic             core_loadKey,
  output logic [M*N-1:0]   core_key,
  output logic             core_enc_dec,
  output logic             core_newData,
  input  logic             core_loadData,
  output logic [2*N-1:0]   core_inData,
  input  logic             core_doneData,
  output logic             core_readData,
  input  logic [2*N-1:0]   core_outData
`ifdef SIMON_CBC_EN
  ,
  input  logic [2*N-1:0]   iv
`endif
);

  localparam int BW  = 2 * N;
  localparam int IAW = $clog2(IN_DEPTH);
  localparam int ICW = IAW + 1;
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam int OCW = OAW + 1;

  // DRAIN is kept in the encoding as a safe landing state: nothing enters
  // it, and it falls straight back to IDLE.
  typedef enum logic [2:0] {
    IDLE, KEY_REQ, KEY_WAIT, DATA_REQ, RUN, READ, DRAIN
  } state_t;

  state_t state, state_nxt;

  // Handshake decisions
  logic key_take;   // key accepted this cycle
  logic issue;      // FIFO head issued to the core this cycle
  logic push_res;   // core result pushed to the output FIFO this cycle

  // Registered copies of core strobes for rising-edge detection
  logic load_key_q, load_data_q, done_data_q;
  logic load_key_rise, load_data_rise, done_rise;

  logic key_loaded;
  logic key_wait_last;   // second KEY_WAIT cycle

  // ---------------- input FIFO ----------------
  logic [BW-1:0]  in_mem [IN_DEPTH];
  logic [IAW-1:0] in_wr_ptr, in_rd_ptr;
  logic [ICW-1:0] in_count;
  logic           in_empty, in_full, in_push;
  logic [BW-1:0]  in_head;

  // ---------------- output FIFO ---------------
  logic [BW-1:0]  out_mem [OUT_DEPTH];
  logic [OAW-1:0] out_wr_ptr, out_rd_ptr;
  logic [OCW-1:0] out_count;
  logic           out_full, out_pop;

  logic [BW-1:0]  issue_data;
  logic [BW-1:0]  result;

  assign in_empty = (in_count == '0);
  assign in_full  = (in_count == ICW'(IN_DEPTH));
  assign in_ready = nR & ~in_full;
  assign in_push  = in_valid & in_ready;
  assign in_head  = in_mem[in_rd_ptr];

  assign out_full  = (out_count == OCW'(OUT_DEPTH));
  assign out_valid = (out_count != '0);
  assign out_pop   = out_valid & out_ready;
  assign out_block = out_valid ? out_mem[out_rd_ptr] : '0;

  assign busy = (state != IDLE) | ~in_empty | out_valid;

  assign load_key_rise  = core_loadKey  & ~load_key_q;
  assign load_data_rise = core_loadData & ~load_data_q;
  assign done_rise      = core_doneData & ~done_data_q;

  assign key_take = key_valid & key_ready;
  // A free output slot is required before issue, so the later push can
  // never overflow: only one block is in flight and pops only free space.
  assign issue    = (state == IDLE) & ~key_take & key_loaded & ~in_empty & ~out_full;
  assign push_res = (state == RUN) & done_rise;

  // ---------------- FSM: state register ----------------
  // NOTE: sequential state uses <= so every register samples pre-edge
  // values regardless of the order the always blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (!nR) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    // NOTE: default first so every path drives state_nxt; without it a
    // missing branch would infer a latch.
    state_nxt = state;
    case (state)
      IDLE: begin
        if (key_take)   state_nxt = KEY_REQ;
        else if (issue) state_nxt = DATA_REQ;
      end
      KEY_REQ:  if (load_key_rise)  state_nxt = KEY_WAIT;
      KEY_WAIT: if (key_wait_last)  state_nxt = IDLE;
      DATA_REQ: if (load_data_rise) state_nxt = RUN;
      RUN:      if (done_rise)      state_nxt = READ;
      READ:     if (!core_doneData) state_nxt = IDLE;
      DRAIN:    state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    key_ready     = 1'b0;
    core_newKey   = 1'b0;
    core_newData  = 1'b0;
    core_readData = 1'b0;
    case (state)
      // Keys wait for the input FIFO to drain so queued blocks keep the
      // key they were submitted under.
      IDLE:              key_ready     = nR & in_empty;
      KEY_REQ, KEY_WAIT: core_newKey   = 1'b1;
      DATA_REQ:          core_newData  = 1'b1;
      READ:              core_readData = 1'b1;
      default: ;
    endcase
  end

  // ---------------- control / datapath registers ----------------
  always_ff @(posedge clk) begin
    if (!nR) begin
      load_key_q    <= 1'b0;
      load_data_q   <= 1'b0;
      done_data_q   <= 1'b0;
      key_loaded    <= 1'b0;
      key_wait_last <= 1'b0;
      core_key      <= '0;
      core_enc_dec  <= 1'b1;
      core_inData   <= '0;
    end else begin
      load_key_q  <= core_loadKey;
      load_data_q <= core_loadData;
      done_data_q <= core_doneData;

      // newKey stays high for exactly two cycles after the loadKey edge
      key_wait_last <= (state == KEY_WAIT) & ~key_wait_last;
      if (state == KEY_WAIT && key_wait_last) key_loaded <= 1'b1;

      if (key_take) begin
        core_key     <= key_in;
        core_enc_dec <= key_mode;
      end
      if (issue) core_inData <= issue_data;
    end
  end

`ifdef SIMON_CBC_EN
  logic [BW-1:0] chain;
  logic [BW-1:0] blk_q;   // raw input block, the next chain value when decrypting

  assign issue_data = core_enc_dec ? (in_head ^ chain) : in_head;
  assign result     = core_enc_dec ? core_outData : (core_outData ^ chain);

  always_ff @(posedge clk) begin
    if (!nR) begin
      chain <= '0;
      blk_q <= '0;
    end else begin
      if (issue) blk_q <= in_head;
      if (key_take)      chain <= iv;
      else if (push_res) chain <= core_enc_dec ? core_outData : blk_q;
    end
  end
`else
  assign issue_data = in_head;
  assign result     = core_outData;
`endif

  // ---------------- FIFO pointers ----------------
  always_ff @(posedge clk) begin
    if (!nR) begin
      in_wr_ptr  <= '0;
      in_rd_ptr  <= '0;
      in_count   <= '0;
      out_wr_ptr <= '0;
      out_rd_ptr <= '0;
      out_count  <= '0;
    end else begin
      if (in_push) in_wr_ptr <= in_wr_ptr + IAW'(1);
      if (issue)   in_rd_ptr <= in_rd_ptr + IAW'(1);
      case ({in_push, issue})
        2'b10:   in_count <= in_count + ICW'(1);
        2'b01:   in_count <= in_count - ICW'(1);
        default: ;
      endcase

      if (push_res) out_wr_ptr <= out_wr_ptr + OAW'(1);
      if (out_pop)  out_rd_ptr <= out_rd_ptr + OAW'(1);
      case ({push_res, out_pop})
        2'b10:   out_count <= out_count + OCW'(1);
        2'b01:   out_count <= out_count - OCW'(1);
        default: ;
      endcase
    end
  end

  // ---------------- FIFO storage ----------------
  // NOTE: storage is deliberately not reset; only pointers and counts are,
  // and out_block is masked to zero while the output FIFO is empty.
  always_ff @(posedge clk) begin
    if (in_push)  in_mem[in_wr_ptr]   <= in_block;
    if (push_res) out_mem[out_wr_ptr] <= result;
  end

endmodule

// File: tb/tb_simon_stream_ctrl.sv
// ---------------------------------------------------------------------------
// tb_simon_stream_ctrl
//
// Self-checking bench for simon_stream_ctrl. A behavioural SIMON64/128 core
// answers the controller's handshakes; a scoreboard computes each expected
// result from the active key/mode (and CBC chain when SIMON_CBC_EN is set)
// at the moment the host stream accepts the block.
// ---------------------------------------------------------------------------
module tb_simon_stream_ctrl;

  localparam logic [127:0] KEY1 = 128'h1b1a1918_13121110_0b0a0908_03020100;
  localparam logic [63:0]  PT1  = 64'h656b696c20646e75;
  localparam logic [63:0]  CT1  = 64'h44c8fc20b9dfa07a;
  localparam logic [61:0]  Z3   = 62'b11011011101011000110010111100000010010001010011100110100001111;

`ifdef SIMON_CBC_EN
  localparam bit CBC = 1'b1;
`else
  localparam bit CBC = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         nR;
  logic [127:0] key_in;
  logic         key_mode, key_valid, key_ready;
  logic [63:0]  in_block;
  logic         in_valid, in_ready;
  logic [63:0]  out_block;
  logic         out_valid, out_ready, busy;
  logic         core_newKey, core_loadKey;
  logic [127:0] core_key;
  logic         core_enc_dec, core_newData, core_loadData;
  logic [63:0]  core_inData;
  logic         core_doneData, core_readData;
  logic [63:0]  core_outData;
`ifdef SIMON_CBC_EN
  logic [63:0]  iv;
`endif

  always #5 clk = ~clk;

  simon_stream_ctrl dut (
    .clk           (clk),
    .nR            (nR),
    .key_in        (key_in),
    .key_mode      (key_mode),
    .key_valid     (key_valid),
    .key_ready     (key_ready),
    .in_block      (in_block),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .out_block     (out_block),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .busy          (busy),
    .core_newKey   (core_newKey),
    .core_loadKey  (core_loadKey),
    .core_key      (core_key),
    .core_enc_dec  (core_enc_dec),
    .core_newData  (core_newData),
    .core_loadData (core_loadData),
    .core_inData   (core_inData),
    .core_doneData (core_doneData),
    .core_readData (core_readData),
    .core_outData  (core_outData)
`ifdef SIMON_CBC_EN
    ,
    .iv            (iv)
`endif
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- SIMON64/128 reference ----------------
  function automatic logic [31:0] rol(input logic [31:0] v, input int s);
    return (v << s) | (v >> (32 - s));
  endfunction

  function automatic logic [31:0] ror(input logic [31:0] v, input int s);
    return (v >> s) | (v << (32 - s));
  endfunction

  function automatic logic [31:0] rf(input logic [31:0] v);
    return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
  endfunction

  function automatic logic [63:0] simon(input logic [63:0] blk, input logic [127:0] key, input logic enc);
    logic [31:0] k [44];
    logic [31:0] x, y, t;
    for (int i = 0; i < 4; i++) k[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t    = ror(k[i-1], 3) ^ k[i-3];
      t    = t ^ ror(t, 1);
      k[i] = ~k[i-4] ^ t ^ {31'd0, Z3[61 - ((i - 4) % 62)]} ^ 32'd3;
    end
    x = blk[63:32];
    y = blk[31:0];
    if (enc) begin
      for (int i = 0; i < 44; i++) begin
        t = x; x = y ^ rf(x) ^ k[i]; y = t;
      end
    end else begin
      for (int i = 43; i >= 0; i--) begin
        t = y; y = x ^ rf(y) ^ k[i]; x = t;
      end
    end
    return {x, y};
  endfunction

  // ---------------- behavioural core ----------------
  localparam int C_IDLE = 0, C_KLD = 1, C_KHOLD = 2, C_DLD = 3,
                 C_DHOLD = 4, C_COMP = 5, C_DONE = 6, C_RDW = 7;
  int           cs = C_IDLE;
  int           dly = 0;
  int           new_data_cnt = 0;
  int           core_done_cnt = 0;
  logic [127:0] ck;
  logic         cm;
  logic [63:0]  cin;

  always @(posedge clk) begin
    if (!nR) begin
      cs            <= C_IDLE;
      dly           <= 0;
      core_loadKey  <= 1'b0;
      core_loadData <= 1'b0;
      core_doneData <= 1'b0;
      core_outData  <= '0;
    end else begin
      case (cs)
        C_IDLE: begin
          if (core_newKey) begin
            ck  <= core_key;
            cm  <= core_enc_dec;
            dly <= int'($urandom_range(0, 2));
            cs  <= C_KLD;
          end else if (core_newData) begin
            cin          <= core_inData;
            dly          <= int'($urandom_range(0, 2));
            new_data_cnt <= new_data_cnt + 1;
            cs           <= C_DLD;
          end
        end
        C_KLD:   if (dly == 0) begin core_loadKey <= 1'b1; cs <= C_KHOLD; end else dly <= dly - 1;
        C_KHOLD: if (!core_newKey) begin core_loadKey <= 1'b0; cs <= C_IDLE; end
        C_DLD:   if (dly == 0) begin core_loadData <= 1'b1; cs <= C_DHOLD; end else dly <= dly - 1;
        C_DHOLD: if (!core_newData) begin
          core_loadData <= 1'b0;
          dly           <= int'($urandom_range(1, 4));
          cs            <= C_COMP;
        end
        C_COMP: if (dly == 0) begin
          core_outData  <= simon(cin, ck, cm);
          core_doneData <= 1'b1;
          cs            <= C_DONE;
        end else dly <= dly - 1;
        C_DONE: if (core_readData) begin
          core_doneData <= 1'b0;
          core_done_cnt <= core_done_cnt + 1;
          cs            <= C_RDW;
        end
        C_RDW:  if (!core_readData) cs <= C_IDLE;
        default: cs <= C_IDLE;
      endcase
    end
  end

  // ---------------- scoreboard model ----------------
  logic [127:0] m_key;
  logic         m_mode;
  logic [63:0]  m_chain;
  logic [63:0]  exp_q [$];
  logic [63:0]  out_log [$];
  logic [63:0]  last_out;
  bit           rand_ready = 1'b0;

  // Output monitor: samples 1 ns after the negedge at which inputs change.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (nR && out_valid && out_ready) begin
        check("out_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          check("out_block", out_block, exp_q[0]);
          void'(exp_q.pop_front());
        end
        out_log.push_back(out_block);
        last_out = out_block;
      end
    end
  end

  always @(negedge clk) if (rand_ready) out_ready = 1'($urandom_range(0, 1));

  // All tasks start and end right after a negedge.
  task automatic send_key(input logic [127:0] k, input logic mode, input logic [63:0] v);
    bit acc = 1'b0;
    key_in = k; key_mode = mode; key_valid = 1'b1;
`ifdef SIMON_CBC_EN
    iv = v;
`endif
    for (int i = 0; i < 2000 && !acc; i++) begin
      acc = key_ready;
      @(negedge clk);
    end
    key_valid = 1'b0;
    check("key_accept", acc, 1);
    m_key = k; m_mode = mode; m_chain = v;
  endtask

  task automatic send_block(input logic [63:0] b);
    bit          acc = 1'b0;
    logic [63:0] r;
    in_block = b; in_valid = 1'b1;
    for (int i = 0; i < 2000 && !acc; i++) begin
      acc = in_ready;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("block_accept", acc, 1);
    if (CBC) begin
      if (m_mode) begin r = simon(b ^ m_chain, m_key, 1'b1); m_chain = r; end
      else        begin r = simon(b, m_key, 1'b0) ^ m_chain; m_chain = b; end
    end else begin
      r = simon(b, m_key, m_mode);
    end
    exp_q.push_back(r);
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && !busy;
    end
    check("drain", done, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},   in_ready, 0);
    check({tag, "_key_ready"},  key_ready, 0);
    check({tag, "_out_valid"},  out_valid, 0);
    check({tag, "_out_block"},  out_block, 0);
    check({tag, "_newKey"},     core_newKey, 0);
    check({tag, "_newData"},    core_newData, 0);
    check({tag, "_readData"},   core_readData, 0);
    check({tag, "_core_key"},   core_key, 0);
    check({tag, "_inData"},     core_inData, 0);
    check({tag, "_enc_dec"},    core_enc_dec, 1);
    check({tag, "_busy"},       busy, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int nd0, dc0;
    bit ok;
    logic [63:0] p0, p1, c0, c1, ivr;

    nR = 1'b0; key_in = '0; key_mode = 1'b0; key_valid = 1'b0;
    in_block = '0; in_valid = 1'b0; out_ready = 1'b1;
`ifdef SIMON_CBC_EN
    iv = '0;
`endif
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    nR = 1'b1;
    @(negedge clk);

    // Data without a key stays queued; a reset clears it.
    in_block = PT1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("nokey_not_issued", new_data_cnt, 0);
    check("nokey_busy", busy, 1);
    nR = 1'b0;
    @(negedge clk);
    nR = 1'b1;
    @(negedge clk);
    check("nokey_cleared", busy, 0);

    // T1: known-answer encrypt
    send_key(KEY1, 1'b1, 64'd0);
    nd0 = new_data_cnt;
    send_block(PT1);
    wait_drain();
    check("t1_newdata_once", new_data_cnt - nd0, 1);
    check("t1_ct", last_out, CT1);

    // T2: known-answer decrypt
    send_key(KEY1, 1'b0, 64'd0);
    send_block(CT1);
    wait_drain();
    check("t2_pt", last_out, PT1);

    // T3: burst of 5 with the output stalled
    send_key(KEY1, 1'b1, 64'd0);
    out_ready = 1'b0;
    nd0 = new_data_cnt;
    dc0 = core_done_cnt;
    for (int i = 0; i < 5; i++) send_block({$urandom, $urandom});
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      ok = (core_done_cnt - dc0) >= 4;
    end
    check("t3_four_done", ok, 1);
    repeat (12) @(negedge clk);
    check("t3_issued", new_data_cnt - nd0, 4);
    check("t3_newdata_low", core_newData, 0);
    check("t3_out_valid", out_valid, 1);
    out_ready = 1'b1;
    wait_drain();
    check("t3_all_issued", new_data_cnt - nd0, 5);

    // T4: key offered while two blocks are queued
    out_ready = 1'b0;
    dc0 = core_done_cnt;
    send_block({$urandom, $urandom});
    send_block({$urandom, $urandom});
    send_key({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)),
             {$urandom, $urandom});
    check("t4_key_after_both", core_done_cnt - dc0, 2);
    out_ready = 1'b1;
    send_block({$urandom, $urandom});
    send_block({$urandom, $urandom});
    wait_drain();

    // T5: reset during RUN
    send_key(KEY1, 1'b1, 64'd0);
    send_block(PT1);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      ok = (cs == C_COMP);
      if (!ok) @(negedge clk);
    end
    check("t5_reached_run", ok, 1);
    nR = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_reset_outputs("t5");
    nR = 1'b1;
    @(negedge clk);
    send_key(KEY1, 1'b1, 64'd0);
    send_block(PT1);
    wait_drain();
    check("t5_ct_after_reset", last_out, CT1);

    // Random soak with a randomly stalling output
    rand_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send_key({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)),
               {$urandom, $urandom});
      for (int b = 0; b < 6; b++) send_block({$urandom, $urandom});
    end
    wait_drain();
    rand_ready = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;

`ifdef SIMON_CBC_EN
    // T6: CBC round trip
    ivr = {$urandom, $urandom};
    p0  = {$urandom, $urandom};
    p1  = {$urandom, $urandom};
    out_log.delete();
    send_key(KEY1, 1'b1, ivr);
    send_block(p0);
    send_block(p1);
    wait_drain();
    c0 = out_log[0];
    c1 = out_log[1];
    send_key(KEY1, 1'b0, ivr);
    send_block(c0);
    send_block(c1);
    wait_drain();
    check("t6_pt0", out_log[2], p0);
    check("t6_pt1", out_log[3], p1);
`else
    ivr = '0; p0 = '0; p1 = '0; c0 = '0; c1 = '0;
`endif

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
